// File: rtl/miso_fifo_scheduler.sv
// Round-robin drain of a show-ahead FIFO bank into one registered valid/ready output.
// Each channel keeps the grant for up to BURST consecutive pops while another channel is eligible.
module miso_fifo_scheduler #(
    parameter int CHANNEL_BIT = 1,
    parameter int WIDTH       = 8,
    parameter int BURST       = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [(1<<CHANNEL_BIT)-1:0]   enable,
    input  logic [(1<<CHANNEL_BIT)-1:0]   empty,
    output logic                          read_flag,
    output logic [CHANNEL_BIT-1:0]        read_select,
    input  logic [WIDTH-1:0]              read_data,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    output logic [CHANNEL_BIT-1:0]        out_channel,
    input  logic                          out_ready
);

    localparam int             CHANNEL   = 1 << CHANNEL_BIT;
    localparam logic [7:0]     BURST_MAX = 8'(BURST);

    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_data_q, out_data_d;
    logic [CHANNEL_BIT-1:0] out_channel_q, out_channel_d;
    logic [CHANNEL_BIT-1:0] last_q, last_d;
    logic [7:0]             burst_cnt_q, burst_cnt_d;

    logic [CHANNEL-1:0]     elig;
    logic                   space;
    logic                   pop;
    logic                   stick;
    logic                   found;
    logic [CHANNEL_BIT-1:0] grant;
    logic [CHANNEL_BIT-1:0] scan_idx;

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt < BURST_MAX) ? cnt + 8'd1 : BURST_MAX;
    endfunction

    // Grant: stay on last while its burst allowance remains, else rotate from last+1.
    // burst_cnt==0 only after reset, when last has never actually been served,
    // so the rotation starts at channel 0 instead of sticking to CHANNEL-1.
    always_comb begin
        elig     = enable & ~empty;
        space    = ~out_valid_q | out_ready;
        pop      = space & (|elig);
        stick    = elig[last_q] && (burst_cnt_q != 8'd0) && (burst_cnt_q < BURST_MAX);
        grant    = last_q;
        found    = 1'b0;
        scan_idx = last_q;
        if (!stick) begin
            for (int k = 1; k <= CHANNEL; k++) begin
                scan_idx = last_q + CHANNEL_BIT'(k);
                if (!found && elig[scan_idx]) begin
                    grant = scan_idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_channel_d = out_channel_q;
        last_d        = last_q;
        burst_cnt_d   = burst_cnt_q;
        if (pop) begin
            out_valid_d   = 1'b1;
            out_data_d    = read_data;
            out_channel_d = grant;
            last_d        = grant;
            burst_cnt_d   = (grant == last_q) ? sat_inc(burst_cnt_q) : 8'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_channel_q <= '0;
            last_q        <= CHANNEL_BIT'(CHANNEL - 1);
            burst_cnt_q   <= 8'd0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_channel_q <= out_channel_d;
            last_q        <= last_d;
            burst_cnt_q   <= burst_cnt_d;
        end
    end

    assign read_flag   = pop & RST;
    assign read_select = pop ? grant : last_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_channel = out_channel_q;

endmodule
